// File: rtl/uart_echo_engine_pkg.sv
// Shared types and the word transform for the UART echo engine.
// The transform works on a wide word; callers keep the low DATA_WIDTH bits (mod 2^DATA_WIDTH).
package uart_echo_pkg;

   localparam int XFORM_W = 64;

   typedef enum logic [1:0] {
      PASS = 2'd0,
      INC  = 2'd1,
      ADD  = 2'd2,
      INV  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_IDLE = 2'd3
   } state_t;

   function automatic logic [XFORM_W-1:0] transform(input mode_t mode,
                                                    input logic [XFORM_W-1:0] data,
                                                    input logic [XFORM_W-1:0] addend);
      logic [XFORM_W-1:0] result;
      result = data;
      case (mode)
         PASS:    result = data;
         INC:     result = data + XFORM_W'(1);
         ADD:     result = data + addend;
         INV:     result = ~data;
         default: result = data;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_echo_engine_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push on full is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  ireset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           level
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge ireset) begin
      if (!ireset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; on full with a pop, tail and head share an address and the read happens first.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_echo_engine.sv
// Buffered echo engine: queues received words, transforms them at pop and replays them to the transmitter.
module uart_echo_engine
   import uart_echo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 16,
   localparam int LW        = $clog2(DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  ireset,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  tx_idle,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] addend,
   input  logic                  clear_stats,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_send,
   output logic [LW-1:0]         fifo_level,
   output logic                  overflow,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   state_t                state;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic                  drop;
   logic [XFORM_W-1:0]    xform_full;

   // Handshake: a word leaves on the one-cycle tx_send strobe; the transmitter then shows busy (tx_idle=0)
   // and returns to idle before the next word may be popped.
   assign pop  = (state == IDLE) && !fifo_empty && tx_idle;
   assign drop = rx_valid && fifo_full && !pop;

   assign xform_full = transform(mode_t'(mode), XFORM_W'(fifo_head), XFORM_W'(addend));

   generate
      if (DATA_WIDTH < XFORM_W) begin : g_trunc
         logic xform_unused_bits;
         assign xform_unused_bits = ^xform_full[XFORM_W-1:DATA_WIDTH];
      end
   endgenerate

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .ireset    (ireset),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clock or negedge ireset) begin
      if (!ireset) begin
         state   <= IDLE;
         tx_data <= '0;
         tx_send <= 1'b0;
      end else begin
         tx_send <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= xform_full[DATA_WIDTH-1:0];
                  tx_send <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND:      state <= WAIT_BUSY;
            WAIT_BUSY: if (!tx_idle) state <= WAIT_IDLE;
            WAIT_IDLE: if (tx_idle)  state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // A drop in the same cycle as clear_stats wins, leaving a count of one.
   always_ff @(posedge clock or negedge ireset) begin
      if (!ireset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_stats)
            drop_count <= CNT_WIDTH'(1);
         else if (drop_count != {CNT_WIDTH{1'b1}})
            drop_count <= drop_count + CNT_WIDTH'(1);
      end else if (clear_stats) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule
